// File: rtl/apb_bridge_pkg.sv
// ============================================================================
// apb_bridge_pkg : shared state encoding and helpers for the APB core bridge
// Revision: 1.0
// ============================================================================
`default_nettype none

package apb_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_br_state_e;

   localparam logic [63:0] ERR_RDATA = '0;

   function automatic logic [63:0] word_align(input logic [63:0] addr);
      return {addr[63:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_bridge_timeout.sv
// ============================================================================
// apb_bridge_timeout : saturating ACCESS-phase wait counter with expiry flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_bridge_timeout #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int unsigned c_cnt_w = $clog2(LIMIT + 1);
   localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(LIMIT - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != c_max)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == c_max);

endmodule

`default_nettype wire

// File: rtl/apb_core_bridge.sv
// ============================================================================
// apb_core_bridge : req/gnt/rvalid data port to single APB3 transfers + PSTRB
// Optional ACCESS timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_core_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        data_req_i,
   output logic                        data_gnt_o,
   input  logic                        data_we_i,
   input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
   input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
   input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
   output logic                        data_rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
   output logic                        data_err_o,
   output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
   output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
   output logic [APB_DATA_WIDTH/8-1:0] pstrb_o,
   output logic                        pwrite_o,
   output logic                        psel_o,
   output logic                        penable_o,
   input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
   input  logic                        pready_i,
   input  logic                        pslverr_i
);

   localparam int unsigned c_strb_w = APB_DATA_WIDTH / 8;

   apb_br_state_e r_state, w_state_nxt;

   logic                      w_take;
   logic                      w_done;
   logic                      w_abort;
   logic                      w_timeout;
   logic [APB_ADDR_WIDTH-1:0] r_paddr;
   logic [APB_DATA_WIDTH-1:0] r_pwdata;
   logic [c_strb_w-1:0]       r_pstrb;
   logic                      r_pwrite;
   logic                      r_psel;
   logic                      r_penable;
   logic                      r_rvalid;
   logic [APB_DATA_WIDTH-1:0] r_rdata;
   logic                      r_err;

   assign w_take  = (r_state == IDLE) && data_req_i;
   assign w_done  = (r_state == ACCESS) && pready_i;
   assign w_abort = (r_state == ACCESS) && !pready_i && w_timeout;

`ifdef APB_BRIDGE_TIMEOUT_EN
   apb_bridge_timeout #(
      .LIMIT     (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .i_clr     (w_take),
      .i_inc     ((r_state == ACCESS) && !pready_i),
      .o_expired (w_timeout)
   );
`else
   localparam int unsigned c_timeout_unused = TIMEOUT_CYCLES;
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_take) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = ACCESS;
         ACCESS:  if (w_done || w_abort) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // APB control is decoded from the next state so every output comes straight from a flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_pwrite  <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_psel    <= (w_state_nxt != IDLE);
         r_penable <= (w_state_nxt == ACCESS);
         r_rvalid  <= w_done || w_abort;
         if (w_take) begin
            r_paddr  <= APB_ADDR_WIDTH'(word_align(64'(data_addr_i)));
            r_pwdata <= data_wdata_i;
            r_pwrite <= data_we_i;
            r_pstrb  <= data_we_i ? data_be_i : '0;
         end
         if (w_done) begin
            r_err   <= pslverr_i;
            r_rdata <= (pslverr_i || r_pwrite) ? APB_DATA_WIDTH'(ERR_RDATA) : prdata_i;
         end else if (w_abort) begin
            r_err   <= 1'b1;
            r_rdata <= APB_DATA_WIDTH'(ERR_RDATA);
         end
      end
   end

   assign data_gnt_o    = w_take;
   assign data_rvalid_o = r_rvalid;
   assign data_rdata_o  = r_rdata;
   assign data_err_o    = r_err;
   assign paddr_o       = r_paddr;
   assign pwdata_o      = r_pwdata;
   assign pstrb_o       = r_pstrb;
   assign pwrite_o      = r_pwrite;
   assign psel_o        = r_psel;
   assign penable_o     = r_penable;

endmodule

`default_nettype wire
